// File: rtl/sram128x64_arbiter.sv
// Zero-fill controller and two-requester round-robin arbiter for a
// 128x64 1R/1W dual-port SRAM macro with bit write enables.
//
// Ports:
//   clk, reset_n          clock (also macro CLKA/CLKB), async active-low reset
//   Flush                 re-initialise the whole array
//   Ready                 array initialised, grants possible
//   RdReq/RdAdr           per-requester read request and address
//   RdGnt/RdValid/RdData  read grant (same cycle), valid + data (next cycle)
//   WrReq/WrAdr/WrData    per-requester write request, address, data
//   WrByteEn/WrGnt        per-requester byte enables, write grant
//   CEBA..BWEBA, QA       macro port A (read-only)
//   CEBB..BWEBB           macro port B (write-only), active-low controls
module sram128x64_arbiter #(
   parameter int                ADDRW   = 7,
   parameter int                WORDW   = 64,
   parameter logic [WORDW-1:0]  INITVAL = '0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          Flush,
   output logic                          Ready,
   input  logic [1:0]                    RdReq,
   input  logic [1:0][ADDRW-1:0]         RdAdr,
   output logic [1:0]                    RdGnt,
   output logic [1:0]                    RdValid,
   output logic [WORDW-1:0]              RdData,
   input  logic [1:0]                    WrReq,
   input  logic [1:0][ADDRW-1:0]         WrAdr,
   input  logic [1:0][WORDW-1:0]         WrData,
   input  logic [1:0][WORDW/8-1:0]       WrByteEn,
   output logic [1:0]                    WrGnt,
   output logic                          CEBA,
   output logic                          WEBA,
   output logic [ADDRW-1:0]              AA,
   output logic [WORDW-1:0]              DA,
   output logic [WORDW-1:0]              BWEBA,
   input  logic [WORDW-1:0]              QA,
   output logic                          CEBB,
   output logic                          WEBB,
   output logic [ADDRW-1:0]              AB,
   output logic [WORDW-1:0]              DB,
   output logic [WORDW-1:0]              BWEBB
);

   localparam int NB = WORDW / 8;
   localparam logic [ADDRW-1:0] LAST = '1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ADDRW-1:0]   initcnt_q, initcnt_d;
   logic               rdpri_q, rdpri_d;
   logic               wrpri_q, wrpri_d;
   logic [ADDRW-1:0]   aa_q;
   logic [ADDRW-1:0]   ab_q;
   logic [WORDW-1:0]   db_q;
   logic [1:0]         rdvalid_q;
   logic               byp_q;
   logic [WORDW-1:0]   bypd_q;
   logic [NB-1:0]      bypbe_q;

   logic               run_ok;
   logic [1:0]         rd_gnt, wr_gnt;
   logic               rd_sel, wr_sel;
   logic               byp_d;
   logic [WORDW-1:0]   rd_mux;

   // Both requesters active: pri picks the winner (0 -> req 0).
   function automatic logic [1:0] arb(input logic [1:0] req,
                                      input logic       pri);
      logic [1:0] g;
      g = req;
      if (req == 2'b11)
         g = pri ? 2'b10 : 2'b01;
      return g;
   endfunction

   // ---------------- state machine ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= INIT;
         initcnt_q <= '0;
      end else begin
         state_q   <= state_d;
         initcnt_q <= initcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      initcnt_d = initcnt_q;
      unique case (state_q)
         INIT: begin
            if (Flush) begin
               initcnt_d = '0;
            end else if (initcnt_q == LAST) begin
               state_d   = RUN;
               initcnt_d = '0;
            end else begin
               initcnt_d = initcnt_q + 1'b1;
            end
         end
         RUN: begin
            if (Flush) begin
               state_d   = INIT;
               initcnt_d = '0;
            end
         end
         default: begin
            state_d   = INIT;
            initcnt_d = '0;
         end
      endcase
   end

   assign Ready = (state_q == RUN);

   // ---------------- arbitration ----------------
   // Flush in RUN suppresses grants so the sweep starts clean.
   assign run_ok = reset_n && (state_q == RUN) && !Flush;

   always_comb begin
      rd_gnt  = 2'b00;
      wr_gnt  = 2'b00;
      if (run_ok) begin
         rd_gnt = arb(RdReq, rdpri_q);
         wr_gnt = arb(WrReq, wrpri_q);
      end
      rd_sel  = rd_gnt[1];
      wr_sel  = wr_gnt[1];
      rdpri_d = rdpri_q;
      wrpri_d = wrpri_q;
      if (|rd_gnt)
         rdpri_d = ~rd_sel;
      if (|wr_gnt)
         wrpri_d = ~wr_sel;
   end

   assign RdGnt = rd_gnt;
   assign WrGnt = wr_gnt;

   // ---------------- port A (read) ----------------
   always_comb begin
      CEBA  = ~|rd_gnt;
      WEBA  = 1'b1;
      DA    = '0;
      BWEBA = '1;
      AA    = aa_q;
      if (|rd_gnt)
         AA = RdAdr[rd_sel];
   end

   // ---------------- port B (write) ----------------
   always_comb begin
      CEBB  = 1'b1;
      WEBB  = 1'b1;
      AB    = ab_q;
      DB    = db_q;
      BWEBB = '1;
      if (reset_n && state_q == INIT) begin
         CEBB  = 1'b0;
         WEBB  = 1'b0;
         AB    = initcnt_q;
         DB    = INITVAL;
         BWEBB = '0;
      end else if (|wr_gnt) begin
         CEBB = 1'b0;
         WEBB = 1'b0;
         AB   = WrAdr[wr_sel];
         DB   = WrData[wr_sel];
         for (int b = 0; b < NB; b++)
            BWEBB[8*b +: 8] = {8{~WrByteEn[wr_sel][b]}};
      end
   end

   // Macro read-during-write is undefined, so forward the write.
   assign byp_d = (|rd_gnt) && (|wr_gnt) && (AA == AB);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdpri_q   <= 1'b0;
         wrpri_q   <= 1'b0;
         aa_q      <= '0;
         ab_q      <= '0;
         db_q      <= '0;
         rdvalid_q <= 2'b00;
         byp_q     <= 1'b0;
         bypd_q    <= '0;
         bypbe_q   <= '0;
      end else begin
         rdpri_q   <= rdpri_d;
         wrpri_q   <= wrpri_d;
         aa_q      <= AA;
         ab_q      <= AB;
         db_q      <= DB;
         rdvalid_q <= rd_gnt;
         byp_q     <= byp_d;
         if (byp_d) begin
            bypd_q  <= WrData[wr_sel];
            bypbe_q <= WrByteEn[wr_sel];
         end
      end
   end

   // ---------------- read return ----------------
   always_comb begin
      rd_mux = QA;
      if (byp_q) begin
         for (int b = 0; b < NB; b++)
            if (bypbe_q[b])
               rd_mux[8*b +: 8] = bypd_q[8*b +: 8];
      end
      RdData = reset_n ? rd_mux : '0;
   end

   assign RdValid = rdvalid_q;

endmodule

// File: tb/tb_sram128x64_arbiter.sv
// Bench for sram128x64_arbiter: behavioural macro, reference array,
// arbitration model and a read-return scoreboard.
module tb_sram128x64_arbiter;

   logic              clk;
   logic              reset_n;
   logic              Flush;
   logic              Ready;
   logic [1:0]        RdReq;
   logic [1:0][6:0]   RdAdr;
   logic [1:0]        RdGnt;
   logic [1:0]        RdValid;
   logic [63:0]       RdData;
   logic [1:0]        WrReq;
   logic [1:0][6:0]   WrAdr;
   logic [1:0][63:0]  WrData;
   logic [1:0][7:0]   WrByteEn;
   logic [1:0]        WrGnt;
   logic              CEBA, WEBA;
   logic [6:0]        AA;
   logic [63:0]       DA, BWEBA, QA;
   logic              CEBB, WEBB;
   logic [6:0]        AB;
   logic [63:0]       DB, BWEBB;

   sram128x64_arbiter dut (
      .clk(clk), .reset_n(reset_n), .Flush(Flush), .Ready(Ready),
      .RdReq(RdReq), .RdAdr(RdAdr), .RdGnt(RdGnt),
      .RdValid(RdValid), .RdData(RdData),
      .WrReq(WrReq), .WrAdr(WrAdr), .WrData(WrData),
      .WrByteEn(WrByteEn), .WrGnt(WrGnt),
      .CEBA(CEBA), .WEBA(WEBA), .AA(AA), .DA(DA), .BWEBA(BWEBA),
      .QA(QA),
      .CEBB(CEBB), .WEBB(WEBB), .AB(AB), .DB(DB), .BWEBB(BWEBB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural macro: read returns the pre-write value on collision.
   logic [63:0] smem [128];
   always @(posedge clk) begin
      if (!CEBA)
         QA <= smem[AA];
      if (!CEBB && !WEBB)
         smem[AB] <= (smem[AB] & BWEBB) | (DB & ~BWEBB);
   end

   typedef struct {
      logic [1:0]  who;
      logic [63:0] data;
      int          due;
   } rd_exp_t;

   rd_exp_t     sb [$];
   logic [63:0] ref_mem [128];
   int          n_chk;
   int          n_pass;
   int          cyc_n;
   int          init_left;
   logic        rpri, wpri;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
   endtask

   function automatic logic [1:0] arb_m(input logic [1:0] req,
                                        input logic       pri);
      if (req == 2'b11)
         return pri ? 2'b10 : 2'b01;
      return req;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old,
                                         input logic [63:0] nw,
                                         input logic [7:0]  be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [63:0] bwe(input logic [7:0] be);
      logic [63:0] r;
      for (int b = 0; b < 8; b++)
         r[8*b +: 8] = be[b] ? 8'h00 : 8'hFF;
      return r;
   endfunction

   task automatic clear_ref();
      for (int i = 0; i < 128; i++)
         ref_mem[i] = 64'h0;
   endtask

   task automatic idle_in();
      Flush = 1'b0;
      RdReq = 2'b00;
      WrReq = 2'b00;
   endtask

   // One clock cycle: sample at negedge, then advance past posedge.
   task automatic tick();
      rd_exp_t     e;
      logic [1:0]  erg, ewg;
      logic        ri, wi;
      logic [6:0]  radr, wadr;
      logic [63:0] ev;
      @(negedge clk);
      cyc_n++;
      if (sb.size() > 0 && sb[0].due == cyc_n) begin
         e = sb.pop_front();
         chk("rdvalid", 64'(RdValid), 64'(e.who));
         chk("rddata", RdData, e.data);
      end else begin
         chk("rdvalid_idle", 64'(RdValid), 64'h0);
      end
      if (init_left > 0) begin
         chk("ready_init", 64'(Ready), 64'h0);
         chk("gnt_init", 64'({RdGnt, WrGnt}), 64'h0);
         chk("init_ab", 64'(AB), 64'(128 - init_left));
         chk("init_ctl", 64'({CEBB, WEBB}), 64'h0);
         chk("init_db", DB, 64'h0);
         if (Flush) init_left = 128;
         else init_left--;
      end else begin
         chk("ready", 64'(Ready), 64'h1);
         if (Flush) begin
            chk("gnt_flush", 64'({RdGnt, WrGnt}), 64'h0);
            init_left = 128;
            clear_ref();
         end else begin
            erg = arb_m(RdReq, rpri);
            ewg = arb_m(WrReq, wpri);
            chk("rdgnt", 64'(RdGnt), 64'(erg));
            chk("wrgnt", 64'(WrGnt), 64'(ewg));
            chk("ceba", 64'(CEBA), 64'(erg == 2'b00));
            chk("cebb", 64'(CEBB), 64'(ewg == 2'b00));
            ri   = erg[1];
            wi   = ewg[1];
            radr = RdAdr[ri];
            wadr = WrAdr[wi];
            if (erg != 2'b00) begin
               rpri = ~ri;
               chk("aa", 64'(AA), 64'(radr));
               ev = ref_mem[radr];
               if (ewg != 2'b00 && wadr == radr)
                  ev = merge(ev, WrData[wi], WrByteEn[wi]);
               e.who  = erg;
               e.data = ev;
               e.due  = cyc_n + 1;
               sb.push_back(e);
            end
            if (ewg != 2'b00) begin
               wpri = ~wi;
               chk("ab", 64'(AB), 64'(wadr));
               chk("db", DB, WrData[wi]);
               chk("bwebb", BWEBB, bwe(WrByteEn[wi]));
               ref_mem[wadr] = merge(ref_mem[wadr], WrData[wi],
                                     WrByteEn[wi]);
            end else begin
               chk("bwebb_idle", BWEBB, {64{1'b1}});
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      chk("rst_ready", 64'(Ready), 64'h0);
      chk("rst_gnt", 64'({RdGnt, WrGnt}), 64'h0);
      chk("rst_rdvalid", 64'(RdValid), 64'h0);
      chk("rst_ce_we", 64'({CEBA, CEBB, WEBA, WEBB}), 64'hF);
      chk("rst_aa_ab", 64'({AA, AB}), 64'h0);
      chk("rst_bwebb", BWEBB, {64{1'b1}});
      chk("rst_db", DB, 64'h0);
      chk("rst_rddata", RdData, 64'h0);
      sb.delete();
      clear_ref();
      rpri = 1'b0;
      wpri = 1'b0;
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      init_left = 128;
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 300 && init_left > 0; k++)
         tick();
   endtask

   task automatic wr1(input logic r, input logic [6:0] a,
                      input logic [63:0] d, input logic [7:0] be);
      WrReq       = r ? 2'b10 : 2'b01;
      WrAdr[r]    = a;
      WrData[r]   = d;
      WrByteEn[r] = be;
   endtask

   task automatic rd1(input logic r, input logic [6:0] a);
      RdReq    = r ? 2'b10 : 2'b01;
      RdAdr[r] = a;
   endtask

   int lat;

   initial begin
      n_chk = 0; n_pass = 0; cyc_n = 0; init_left = 0;
      rpri = 1'b0; wpri = 1'b0;
      reset_n = 1'b0;
      RdAdr = '0; WrAdr = '0; WrData = '0; WrByteEn = '0;
      QA = '0;
      idle_in();
      for (int i = 0; i < 128; i++)
         smem[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
      #12;
      do_reset();
      wait_ready();

      // full sweep read from requester 0
      for (int a = 0; a < 128; a++) begin
         rd1(1'b0, 7'(a));
         tick();
      end
      idle_in();
      tick();

      // write then read back
      wr1(1'b1, 7'd5, 64'h1122334455667788, 8'hFF);
      tick();
      idle_in();
      rd1(1'b1, 7'd5);
      tick();
      idle_in();
      tick();

      // round robin, reads then writes
      RdReq = 2'b11; RdAdr[0] = 7'd5; RdAdr[1] = 7'd0;
      repeat (4) tick();
      idle_in();
      tick();
      WrReq = 2'b11;
      WrAdr[0] = 7'd10; WrData[0] = 64'h0101_0202_0303_0404;
      WrByteEn[0] = 8'hF0;
      WrAdr[1] = 7'd11; WrData[1] = 64'h5555_6666_7777_8888;
      WrByteEn[1] = 8'h3C;
      repeat (4) tick();
      idle_in();
      RdReq = 2'b11; RdAdr[0] = 7'd10; RdAdr[1] = 7'd11;
      repeat (2) tick();
      idle_in();
      tick();

      // same-cycle same-address bypass with partial enables
      wr1(1'b0, 7'd9, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      tick();
      idle_in();
      rd1(1'b0, 7'd9);
      wr1(1'b1, 7'd9, 64'h0, 8'h0F);
      tick();
      idle_in();
      tick();
      // one requester holds both ports
      rd1(1'b1, 7'd9);
      wr1(1'b1, 7'd20, 64'h0F0F_0F0F_0F0F_0F0F, 8'h81);
      tick();
      rd1(1'b1, 7'd20);
      wr1(1'b1, 7'd20, 64'hCAFE_F00D_1234_5678, 8'h5A);
      tick();
      idle_in();
      tick();

      // flush wipes contents; no grants while re-initialising
      wr1(1'b0, 7'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      tick();
      idle_in();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      RdReq = 2'b11; WrReq = 2'b11;
      for (int k = 0; k < 300 && init_left > 100; k++)
         tick();
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      wait_ready();
      idle_in();
      rd1(1'b0, 7'd3);
      tick();
      idle_in();
      tick();

      // reset while a read is outstanding
      rd1(1'b0, 7'd3);
      tick();
      idle_in();
      do_reset();
      // reset again in the middle of the sweep
      for (int k = 0; k < 300 && init_left > 68; k++)
         tick();
      chk("mid_init_ab", 64'(AB), 64'd60);
      do_reset();
      lat = 0;
      for (int k = 0; k < 300 && !Ready; k++) begin
         tick();
         lat++;
      end
      chk("ready_latency", 64'(lat), 64'd128);
      rd1(1'b1, 7'd60);
      tick();
      idle_in();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram128x64_arbiter.md
# sram128x64_arbiter

Controller and two-requester arbiter for the 128x64 one-read/one-write dual-port SRAM macro with bit write enables. It zero-fills the array after reset or on flush, then shares the read port (A) and the write port (B) independently between two requesters with round-robin priority. It also forwards same-cycle same-address write data into the read result, because the macro's read-during-write behaviour is undefined. It sits between cache/predictor-table logic and the SRAM wrapper; the macro's CLKA/CLKB are driven from the same clk.

## Interface
- ADDRW, 7, word address width (128 entries)
- WORDW, 64, data width; byte enables are WORDW/8 = 8 bits
- INITVAL, 64'h0, value written to every entry during init

Ports:
- clk  in  1  clock, also drives macro CLKA/CLKB
- reset_n  in  1  asynchronous active-low reset
- Flush  in  1  request re-initialisation of the whole array
- Ready  out  1  array initialised; grants possible
- RdReq  in  2  read request per requester
- RdAdr  in  2x7  read address per requester
- RdGnt  out  2  read grant, one-hot or zero
- RdValid  out  2  read data valid for requester i, one-hot or zero
- RdData  out  64  read data, shared
- WrReq  in  2  write request per requester
- WrAdr  in  2x7  write address per requester
- WrData  in  2x64  write data per requester
- WrByteEn  in  2x8  byte enables per requester, active-high
- WrGnt  out  2  write grant, one-hot or zero
- CEBA, WEBA, AA, DA, BWEBA  out  1,1,7,64,64  port A (read-only): WEBA=1, DA=0, BWEBA=all ones, constant
- QA  in  64  port A read data, valid the cycle after CEBA=0
- CEBB, WEBB, AB, DB, BWEBB  out  1,1,7,64,64  port B (write-only): active-low chip, write, and bit enables

## Operation
- States: INIT, RUN. The reset state is INIT with InitCnt=0.
- INIT:
  - Each cycle write INITVAL to AB=InitCnt: CEBB=0, WEBB=0, BWEBB=0.
  - Increment InitCnt.
  - At InitCnt=127, the next state is RUN.
  - Ready=0, and all grants are 0.
- RUN:
  - Ready=1.
  - Flush=1 in RUN: no grants that cycle; next state is INIT with InitCnt=0.
  - Flush=1 in INIT: InitCnt restarts at 0.
- Read arbitration:
  - Only one requester active: grant it.
  - Both active: grant the one indicated by RdPri.
  - After any grant, RdPri points to the non-granted requester.
  - On a read grant: CEBA=0 and AA=granted RdAdr. Otherwise CEBA=1 and AA holds its last value.
- Write arbitration: identical to read arbitration, with its own pointer WrPri.
  - CEBB=0, WEBB=0, AB=WrAdr, DB=WrData.
  - BWEBB[8b+7:8b] = ~WrByteEn[b] for each byte b.
  - No write grant in RUN: CEBB=1, WEBB=1, BWEBB=all ones.
- Read and write grants in the same cycle are independent. One requester may hold both.
- Bypass: if a read grant and a write grant coincide and AA==AB:
  - Register the write data and byte enables.
  - Next cycle, RdData byte b = bypass byte if its enable is set, else QA byte b.
  - Otherwise RdData=QA.
- A read granted in the last RUN cycle before INIT still returns RdValid and data in the following cycle.

## Timing
- Reset values (while reset_n=0):
  - Ready=0, RdGnt=WrGnt=RdValid=0.
  - CEBA=CEBB=WEBA=WEBB=1, AA=AB=0, BWEBB=all ones, DB=0.
  - RdPri=WrPri=0, RdData=0, state INIT, InitCnt=0.
- The first init write occurs in the first cycle after reset_n deasserts. After 128 init cycles, Ready=1 in cycle 129.
- Flush sampled at the edge ending cycle N gives init writes in cycles N+1..N+128 and Ready=1 in N+129.
- Grants and SRAM control signals are combinational from requests in the same cycle.
- Read latency is 1: a grant in cycle N gives RdValid[i]=1 and valid RdData in N+1 only.
- A write granted in cycle N is visible to a read granted in N+1 or later. Same-cycle visibility is provided only by the bypass.
- An async reset mid-INIT or mid-read aborts immediately: RdValid=0 and the sweep restarts at address 0.

## Test plan
- Reset release, then read all 128 addresses from requester 0 -> Ready rises after 128 cycles; every RdData=0; RdValid=01 one cycle after each grant.
- Write requester 1, address 5, data 64'h1122334455667788, byte enables 8'hFF. Next cycle read address 5 -> RdData=64'h1122334455667788.
- Both requesters hold RdReq for 4 cycles -> RdGnt sequence 01,10,01,10. Same check for WrReq.
- Read address 9 (old value 64'hAAAA_AAAA_AAAA_AAAA). In the same cycle, write address 9 with data 64'h0 and byte enables 8'h0F -> next cycle RdData=64'hAAAA_AAAA_0000_0000.
- Write 64'hFFFF... to address 3, pulse Flush, wait for Ready, then read address 3 -> 0. No grants for 128 cycles; Ready=0 during that time.
- Assert reset_n=0 at InitCnt=60, then release -> Ready rises exactly 128 cycles after the release.
